ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Registered EX->MEM stage directly downstream of the ALU; captures ALUResult/Zero plus control.
//  Resolves BNE (taken when Zero==0) and performs LB/SB on a byte-addressable data memory.
//  Produces write-back data for the register file.
//  Squashes the younger instruction in EX when a branch is taken.
// PARAMETERS
//  MEM_BYTES  1024  data memory size in bytes; power of two
//  ADDR_W     10    byte address bits used, = $clog2(MEM_BYTES)
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   synchronous, active-high
//  in_valid       in   1   EX holds a valid instruction
//  in_ready       out  1   stage can accept; = ~stall
//  stall          in   1   downstream hold; freezes the stage register
//  alu_result     in   32  ALUResult (address for LB/SB, value for ADD/AND/ORI/SLL)
//  alu_zero       in   1   ALU Zero flag
//  store_data     in   32  rs2 value; bits [7:0] used by SB
//  branch_target  in   32  PC+imm computed in EX
//  ctl_branch     in   1   BNE
//  ctl_mem_read   in   1   LB
//  ctl_mem_write  in   1   SB
//  ctl_reg_write  in   1   writes rd
//  ctl_mem_to_reg in   1   wb_data from memory, not the ALU
//  rd             in   5   destination register
//  out_valid      out  1   stage register valid
//  wb_data        out  32  write-back value
//  wb_rd          out  5   registered rd
//  wb_reg_write   out  1   out_valid & reg_write & (rd!=0)
//  pc_src         out  1   branch taken; selects pc_target
//  pc_target      out  32  registered branch_target
//  flush          out  1   = pc_src; upstream IF/ID must squash
// BEHAVIOUR
//  - Reset (sync): valid=0 and all stage fields=0. Outputs are then 0: out_valid, wb_*, pc_src, flush, pc_target.
//    Memory contents are not reset.
//  - Capture: at the edge where reset=0 and stall=0, the stage register loads (in_valid & ~pc_src) and all inputs.
//    A taken branch therefore squashes the instruction in EX during the same cycle.
//  - stall=1: the stage register holds its value; no memory write occurs.
//    pc_src=0 while stalled and asserts in the first unstalled cycle, so each branch redirects exactly once.
//  - Latency: an instruction accepted at edge N is visible on wb_*/pc_src during cycle N..N+1.
//    Load data is an asynchronous read, valid in the same cycle; SB commits at edge N+1.
//  - pc_src = out_valid & branch & ~zero & ~stall.
//  - Memory address: addr = alu_result[ADDR_W-1:0]; upper bits are ignored, so addresses wrap modulo MEM_BYTES.
//  - LB: wb_data = {{24{mem[addr][7]}}, mem[addr]} (sign-extended).
//  - SB: mem[addr] <= store_data[7:0] at the edge ending the cycle in which valid & mem_write & ~stall.
//  - Non-memory ops: wb_data = alu_result.
//  - Decode conflicts: if mem_read and mem_write are both set, treat as a load (the write is suppressed).
//    Only one of {branch, mem_read, mem_write} is legal.
//  - rd=0: wb_reg_write is forced to 0.
//  - Reset mid-operation: a pending SB in the stage is dropped (no write at the reset edge).
//    A taken branch in the stage does not assert pc_src after reset.
//  - Back-to-back SB then LB to the same address: the LB, one cycle later, reads the new byte
//    (the write commits before the LB is in the stage).
// STRUCTURE
//  - Shared package rv_pkg: ALUOp encodings (ADD/LB/SB=4'b0010, AND=4'b0000, ORI=4'b0001,
//    SLL=4'b1000, BNE=4'b0110), XLEN=32, REG_ADDR_W=5, ctl-bundle field widths.
//  - Sub-module data_mem_byte: MEM_BYTES x 8 array, async read, sync write enable.
//  - Top level: stage register, pc_src/flush logic, sign-extend mux.
// TESTING
//  1. Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, pc_src=0, wb_data=0; memory unchanged.
//  2. SB alu_result=0x10, store_data=0xA5, then LB at 0x10 -> wb_data=0xFFFFFFA5, wb_rd as given.
//  3. BNE with zero=0, target=0x40 -> pc_src=flush=1 for 1 cycle, pc_target=0x40.
//     Next EX instruction is squashed (out_valid=0). BNE with zero=1 -> pc_src=0.
//  4. Stall 3 cycles with a BNE(taken) in the stage -> pc_src=0 while stalled, 1 exactly once after release.
//     An SB under stall writes once.
//  5. Wrap: SB at 0x00000400+3 with MEM_BYTES=1024 -> LB at 0x3 returns the stored byte.
//  6. ADD result 0x1234 with rd=0, reg_write=1 -> wb_reg_write=0. Same with rd=5 -> wb_reg_write=1, wb_data=0x1234.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV datapath encodings, widths and control bundle
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_ORI = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_BNE = 4'b0110,
    ALU_SLL = 4'b1000
  } alu_op_e;

  // Loads and stores compute their address with the adder.
  localparam alu_op_e ALU_LB = ALU_ADD;
  localparam alu_op_e ALU_SB = ALU_ADD;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctl_t;

  localparam int CTL_W = $bits(ctl_t);

  function automatic logic [XLEN-1:0] sext_byte(input logic [7:0] b);
    return {{(XLEN-8){b[7]}}, b};
  endfunction

endpackage

// File: rtl/data_mem_byte.sv
// rtl/data_mem_byte.sv - byte-wide data memory, asynchronous read, synchronous write
module data_mem_byte #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM stage register with BNE resolve, LB/SB and write-back mux
module ex_mem_stage
  import rv_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero,
  input  logic [XLEN-1:0]       store_data,
  input  logic [XLEN-1:0]       branch_target,
  input  logic                  ctl_branch,
  input  logic                  ctl_mem_read,
  input  logic                  ctl_mem_write,
  input  logic                  ctl_reg_write,
  input  logic                  ctl_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  out_valid,
  output logic [XLEN-1:0]       wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic                  pc_src,
  output logic [XLEN-1:0]       pc_target,
  output logic                  flush
);

  logic                  valid_q,  valid_d;
  ctl_t                  ctl_q,    ctl_d;
  logic [XLEN-1:0]       alu_q,    alu_d;
  logic                  zero_q,   zero_d;
  logic [7:0]            sdata_q,  sdata_d;
  logic [XLEN-1:0]       target_q, target_d;
  logic [REG_ADDR_W-1:0] rd_q,     rd_d;

  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       unused_sdata_hi;

  // SB only ever stores the low byte of rs2.
  assign unused_sdata_hi = ^store_data[XLEN-1:8];

  assign pc_src   = valid_q & ctl_q.branch & ~zero_q & ~stall;
  assign flush    = pc_src;
  assign in_ready = ~stall;

  always_comb begin
    valid_d  = valid_q;
    ctl_d    = ctl_q;
    alu_d    = alu_q;
    zero_d   = zero_q;
    sdata_d  = sdata_q;
    target_d = target_q;
    rd_d     = rd_q;
    if (!stall) begin
      // A taken branch leaving the stage kills the younger instruction in EX.
      valid_d  = in_valid & ~pc_src;
      ctl_d    = '{branch: ctl_branch, mem_read: ctl_mem_read, mem_write: ctl_mem_write,
                   reg_write: ctl_reg_write, mem_to_reg: ctl_mem_to_reg};
      alu_d    = alu_result;
      zero_d   = alu_zero;
      sdata_d  = store_data[7:0];
      target_d = branch_target;
      rd_d     = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      ctl_q    <= '0;
      alu_q    <= '0;
      zero_q   <= 1'b0;
      sdata_q  <= '0;
      target_q <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctl_q    <= ctl_d;
      alu_q    <= alu_d;
      zero_q   <= zero_d;
      sdata_q  <= sdata_d;
      target_q <= target_d;
      rd_q     <= rd_d;
    end
  end

  // Read wins over write on a conflicting decode; reset drops a pending store.
  assign mem_we = valid_q & ctl_q.mem_write & ~ctl_q.mem_read & ~stall & ~reset;

  data_mem_byte #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (alu_q[ADDR_W-1:0]),
    .wdata_i (sdata_q),
    .rdata_o (mem_rdata)
  );

  assign out_valid    = valid_q;
  assign wb_data      = ctl_q.mem_to_reg ? sext_byte(mem_rdata) : alu_q;
  assign wb_rd        = rd_q;
  assign wb_reg_write = valid_q & ctl_q.reg_write & (rd_q != '0);
  assign pc_target    = target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed bench with an instruction-level model of the EX->MEM stage
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, stall;
  logic [31:0] alu_result, store_data, branch_target;
  logic        alu_zero;
  logic        ctl_branch, ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg;
  logic [4:0]  rd;
  logic        out_valid, wb_reg_write, pc_src, flush;
  logic [31:0] wb_data, pc_target;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_mem_stage #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .stall          (stall),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .store_data     (store_data),
    .branch_target  (branch_target),
    .ctl_branch     (ctl_branch),
    .ctl_mem_read   (ctl_mem_read),
    .ctl_mem_write  (ctl_mem_write),
    .ctl_reg_write  (ctl_reg_write),
    .ctl_mem_to_reg (ctl_mem_to_reg),
    .rd             (rd),
    .out_valid      (out_valid),
    .wb_data        (wb_data),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .flush          (flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently held in the stage plus a byte array.
  typedef struct {
    bit          valid;
    bit          br, mr, mw, rw, m2r, zero;
    logic [31:0] alu, sd, tgt;
    logic [4:0]  rd;
  } instr_t;

  instr_t     m_st;
  logic [7:0] m_mem [1024];
  bit         m_known [1024];

  initial begin
    m_st = '{default: '0};
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_st = '{default: '0};
    end else if (!stall) begin
      bit taken;
      if (m_st.valid && m_st.mw && !m_st.mr) begin
        m_mem[m_st.alu % 1024]   = m_st.sd[7:0];
        m_known[m_st.alu % 1024] = 1'b1;
      end
      taken = m_st.valid && m_st.br && !m_st.zero;
      m_st.valid = in_valid && !taken;
      m_st.br   = ctl_branch;     m_st.mr  = ctl_mem_read;   m_st.mw = ctl_mem_write;
      m_st.rw   = ctl_reg_write;  m_st.m2r = ctl_mem_to_reg; m_st.zero = alu_zero;
      m_st.alu  = alu_result;     m_st.sd  = store_data;     m_st.tgt = branch_target;
      m_st.rd   = rd;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit          exp_taken;
      int          a;
      logic signed [7:0] b;
      exp_taken = m_st.valid && m_st.br && !m_st.zero && !stall;
      a = m_st.alu % 1024;
      check("model.out_valid", 32'(out_valid), 32'(m_st.valid));
      check("model.pc_src", 32'(pc_src), 32'(exp_taken));
      check("model.flush", 32'(flush), 32'(exp_taken));
      check("model.pc_target", pc_target, m_st.tgt);
      check("model.wb_rd", 32'(wb_rd), 32'(m_st.rd));
      check("model.wb_reg_write", 32'(wb_reg_write), 32'(m_st.valid && m_st.rw && m_st.rd != 0));
      check("model.in_ready", 32'(in_ready), 32'(!stall));
      if (!m_st.m2r) begin
        check("model.wb_data_alu", wb_data, m_st.alu);
      end else if (m_known[a]) begin
        b = m_mem[a];
        check("model.wb_data_lb", wb_data, 32'(int'(b)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    in_valid = 0; alu_result = 0; alu_zero = 0; store_data = 0; branch_target = 0;
    ctl_branch = 0; ctl_mem_read = 0; ctl_mem_write = 0; ctl_reg_write = 0;
    ctl_mem_to_reg = 0; rd = 0;
  endtask

  task automatic set_sb(input logic [31:0] addr, input logic [31:0] data);
    set_idle(); in_valid = 1; alu_result = addr; store_data = data; ctl_mem_write = 1;
  endtask

  task automatic set_lb(input logic [31:0] addr, input logic [4:0] r);
    set_idle(); in_valid = 1; alu_result = addr; ctl_mem_read = 1;
    ctl_reg_write = 1; ctl_mem_to_reg = 1; rd = r;
  endtask

  task automatic set_alu(input logic [31:0] res, input logic [4:0] r);
    set_idle(); in_valid = 1; alu_result = res; ctl_reg_write = 1; rd = r;
  endtask

  task automatic set_bne(input logic z, input logic [31:0] tgt);
    set_idle(); in_valid = 1; ctl_branch = 1; alu_zero = z; branch_target = tgt;
  endtask

  initial begin
    reset = 1; stall = 0;
    set_idle();
    step();
    chk_en = 1;
    step();
    reset = 0;

    // Store then immediately load the same byte.
    set_sb(32'h10, 32'hA5);
    step();
    set_lb(32'h10, 5'd7);
    step();
    check("sb_lb.wb_data", wb_data, 32'hFFFF_FFA5);
    check("sb_lb.wb_rd", 32'(wb_rd), 32'd7);
    check("sb_lb.wb_reg_write", 32'(wb_reg_write), 32'd1);

    // Reset with a store in the stage and in_valid held high: store is dropped.
    set_sb(32'h10, 32'h11);
    step();
    reset = 1;
    step();
    step();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.pc_src", 32'(pc_src), 32'd0);
    check("reset.wb_data", wb_data, 32'd0);
    reset = 0;
    set_lb(32'h10, 5'd2);
    step();
    check("reset.mem_kept", wb_data, 32'hFFFF_FFA5);

    // Taken BNE redirects once and squashes the next instruction.
    set_bne(1'b0, 32'h40);
    step();
    check("bne.pc_src", 32'(pc_src), 32'd1);
    check("bne.flush", 32'(flush), 32'd1);
    check("bne.pc_target", pc_target, 32'h40);
    set_alu(32'h99, 5'd3);
    step();
    check("bne.squash", 32'(out_valid), 32'd0);
    check("bne.once", 32'(pc_src), 32'd0);
    set_bne(1'b1, 32'h44);
    step();
    check("bne_nt.pc_src", 32'(pc_src), 32'd0);
    check("bne_nt.out_valid", 32'(out_valid), 32'd1);

    // Taken BNE held by a 3-cycle stall.
    set_bne(1'b0, 32'h80);
    step();
    stall = 1;
    set_alu(32'h77, 5'd4);
    #1 check("stall.pc_src0", 32'(pc_src), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc_src", 32'(pc_src), 32'd0);
    end
    stall = 0;
    #1 check("stall.release", 32'(pc_src), 32'd1);
    step();
    check("stall.after", 32'(pc_src), 32'd0);
    check("stall.squash", 32'(out_valid), 32'd0);

    // Store held under stall, then read back.
    set_sb(32'h20, 32'h5A);
    step();
    stall = 1;
    set_lb(32'h20, 5'd9);
    step(); step();
    stall = 0;
    step();
    check("stall_sb.lb", wb_data, 32'h0000_005A);

    // Conflicting decode behaves as a load; address wraps modulo 1024.
    set_sb(32'h0000_0403, 32'h7E);
    step();
    set_idle(); in_valid = 1; alu_result = 32'h10; store_data = 32'h00;
    ctl_mem_read = 1; ctl_mem_write = 1; ctl_reg_write = 1; ctl_mem_to_reg = 1; rd = 5'd1;
    step();
    check("conflict.load", wb_data, 32'hFFFF_FFA5);
    set_lb(32'h10, 5'd1);
    step();
    check("conflict.no_write", wb_data, 32'hFFFF_FFA5);
    set_lb(32'h3, 5'd6);
    step();
    check("wrap.lb", wb_data, 32'h0000_007E);

    // rd=0 suppresses register write.
    set_alu(32'h1234, 5'd0);
    step();
    check("rd0.wb_reg_write", 32'(wb_reg_write), 32'd0);
    set_alu(32'h1234, 5'd5);
    step();
    check("rd5.wb_reg_write", 32'(wb_reg_write), 32'd1);
    check("rd5.wb_data", wb_data, 32'h0000_1234);

    set_idle();
    step(); step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
